// File: rtl/fetch_pc_seq_pkg.sv
// rtl/fetch_pc_seq_pkg.sv - shared widths and state encoding for the IF-stage PC sequencer
package fetch_pc_seq_pkg;

    localparam int PC_W    = 7;
    localparam int INSTR_W = 32;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        FETCH   = 2'd1,
        HOLD    = 2'd2,
        DISCARD = 2'd3
    } fetch_state_t;

endpackage

// File: rtl/fetch_pc_seq.sv
// rtl/fetch_pc_seq.sv - next-PC sequencer: imem fetch handshake, stall merge, redirect squash
module fetch_pc_seq
    import fetch_pc_seq_pkg::*;
(
    input  logic               clk,
    input  logic               rst_n,
    input  logic [PC_W-1:0]    PCF,
    output logic [PC_W-1:0]    PCin,
    output logic               StallF,
    input  logic               StallHz,
    input  logic               JumpD,
    input  logic [PC_W-1:0]    PCJumpD,
    input  logic               PCSrcD,
    input  logic [PC_W-1:0]    PCBranchD,
    output logic               imem_req,
    output logic [PC_W-1:0]    imem_addr,
    input  logic               imem_ready,
    input  logic [INSTR_W-1:0] imem_rdata,
    output logic [INSTR_W-1:0] InstrF,
    output logic               InstrValidF
);

    fetch_state_t        state, state_d;
    logic [PC_W-1:0]     pend_pc, pend_pc_d;
    logic                pend_v, pend_v_d;
    logic [INSTR_W-1:0]  ibuf, ibuf_d;

    logic                redir;
    logic [PC_W-1:0]     tgt;
    logic [PC_W-1:0]     pc_inc;

    assign redir     = JumpD | PCSrcD;
    assign tgt       = JumpD ? PCJumpD : PCBranchD;
    assign pc_inc    = PCF + PC_W'(1);
    assign imem_addr = PCF;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state   <= IDLE;
            pend_pc <= '0;
            pend_v  <= 1'b0;
            ibuf    <= '0;
        end else begin
            state   <= state_d;
            pend_pc <= pend_pc_d;
            pend_v  <= pend_v_d;
            ibuf    <= ibuf_d;
        end
    end

    always_comb begin
        state_d     = state;
        pend_pc_d   = pend_pc;
        pend_v_d    = pend_v;
        ibuf_d      = ibuf;
        StallF      = 1'b1;
        PCin        = PCF;
        imem_req    = 1'b0;
        InstrF      = '0;
        InstrValidF = 1'b0;

        case (state)
            IDLE: state_d = FETCH;

            FETCH: begin
                imem_req = 1'b1;
                if (imem_ready) begin
                    if (redir) begin
                        StallF = 1'b0;
                        PCin   = tgt;
                    end else begin
                        InstrF      = imem_rdata;
                        InstrValidF = 1'b1;
                        if (StallHz) begin
                            ibuf_d  = imem_rdata;
                            state_d = HOLD;
                        end else begin
                            StallF = 1'b0;
                            PCin   = pc_inc;
                        end
                    end
                end else if (redir) begin
                    // request already in flight cannot be retracted; remember where to go
                    pend_pc_d = tgt;
                    pend_v_d  = 1'b1;
                    state_d   = DISCARD;
                end
            end

            HOLD: begin
                InstrF      = ibuf;
                InstrValidF = ~redir;
                if (redir) begin
                    StallF  = 1'b0;
                    PCin    = tgt;
                    state_d = FETCH;
                end else if (!StallHz) begin
                    StallF  = 1'b0;
                    PCin    = pc_inc;
                    state_d = FETCH;
                end
            end

            DISCARD: begin
                imem_req = 1'b1;
                if (imem_ready) begin
                    StallF   = 1'b0;
                    PCin     = redir ? tgt : (pend_v ? pend_pc : PCF);
                    pend_v_d = 1'b0;
                    state_d  = FETCH;
                end else if (redir) begin
                    pend_pc_d = tgt;
                end
            end

            default: state_d = IDLE;
        endcase
    end

endmodule

// File: tb/tb_fetch_pc_seq.sv
// tb/tb_fetch_pc_seq.sv - directed bench with PC register model, imem model and instr scoreboard
module tb_fetch_pc_seq;
    import fetch_pc_seq_pkg::*;

    logic               clk = 1'b0;
    logic               rst_n;
    logic [PC_W-1:0]    pcf;
    logic [PC_W-1:0]    PCin;
    logic               StallF;
    logic               StallHz;
    logic               JumpD;
    logic [PC_W-1:0]    PCJumpD;
    logic               PCSrcD;
    logic [PC_W-1:0]    PCBranchD;
    logic               imem_req;
    logic [PC_W-1:0]    imem_addr;
    logic               imem_ready;
    logic [INSTR_W-1:0] imem_rdata;
    logic [INSTR_W-1:0] InstrF;
    logic               InstrValidF;

    int total = 0;
    int bad   = 0;
    logic [INSTR_W-1:0] sb[$];

    fetch_pc_seq dut (
        .clk(clk), .rst_n(rst_n), .PCF(pcf), .PCin(PCin), .StallF(StallF),
        .StallHz(StallHz), .JumpD(JumpD), .PCJumpD(PCJumpD), .PCSrcD(PCSrcD),
        .PCBranchD(PCBranchD), .imem_req(imem_req), .imem_addr(imem_addr),
        .imem_ready(imem_ready), .imem_rdata(imem_rdata), .InstrF(InstrF),
        .InstrValidF(InstrValidF)
    );

    always #5 clk = ~clk;

    function automatic logic [INSTR_W-1:0] instr_of(input logic [PC_W-1:0] a);
        return 32'hC0DE_0000 | {25'b0, a};
    endfunction

    assign imem_rdata = instr_of(imem_addr);

    // PC register the sequencer drives
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)       pcf <= '0;
        else if (!StallF) pcf <= PCin;
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic push(input logic [PC_W-1:0] a);
        sb.push_back(instr_of(a));
    endtask

    task automatic pop_chk(input string tag);
        logic [31:0] exp;
        chk({tag, "_valid"}, {31'b0, InstrValidF}, 32'd1);
        exp = (sb.size() != 0) ? sb.pop_front() : 32'hDEAD_BEEF;
        chk({tag, "_instr"}, InstrF, exp);
    endtask

    initial begin
        rst_n = 1'b0; StallHz = 1'b0; JumpD = 1'b0; PCJumpD = '0;
        PCSrcD = 1'b0; PCBranchD = '0; imem_ready = 1'b1;
        #3;
        chk("rst_req",    {31'b0, imem_req},    32'd0);
        chk("rst_stall",  {31'b0, StallF},      32'd1);
        chk("rst_pcin",   {25'b0, PCin},        32'd0);
        chk("rst_valid",  {31'b0, InstrValidF}, 32'd0);
        chk("rst_instr",  InstrF,               32'd0);
        tick();
        rst_n = 1'b1;
        #1;
        chk("idle_req",   {31'b0, imem_req},    32'd0);
        chk("idle_stall", {31'b0, StallF},      32'd1);
        tick();

        // 1: zero-wait imem streams one instruction per cycle
        for (int i = 0; i < 5; i++) begin
            #1;
            chk("t1_pcf",   {25'b0, pcf},    32'(i));
            chk("t1_req",   {31'b0, imem_req}, 32'd1);
            push(PC_W'(i));
            pop_chk("t1");
            chk("t1_pcin",  {25'b0, PCin},   32'(i + 1));
            chk("t1_stall", {31'b0, StallF}, 32'd0);
            tick();
        end

        // 2: three wait cycles at PCF=5
        imem_ready = 1'b0;
        for (int k = 0; k < 3; k++) begin
            #1;
            chk("t2_stall", {31'b0, StallF},      32'd1);
            chk("t2_addr",  {25'b0, imem_addr},   32'd5);
            chk("t2_valid", {31'b0, InstrValidF}, 32'd0);
            tick();
        end
        imem_ready = 1'b1;
        #1;
        push(7'd5);
        pop_chk("t2");
        chk("t2_pcin", {25'b0, PCin}, 32'd6);
        tick();

        // 3: hazard stall as the instruction at PCF=9 arrives
        for (int a = 6; a < 9; a++) begin
            #1;
            chk("t3_pcf", {25'b0, pcf}, 32'(a));
            push(PC_W'(a));
            pop_chk("t3_run");
            tick();
        end
        StallHz = 1'b1;
        #1;
        push(7'd9);
        pop_chk("t3_arrive");
        chk("t3_stall0", {31'b0, StallF}, 32'd1);
        tick();
        imem_ready = 1'b0;
        #1;
        chk("t3_hold_req",   {31'b0, imem_req}, 32'd0);
        chk("t3_hold_stall", {31'b0, StallF},   32'd1);
        push(7'd9);
        pop_chk("t3_hold");
        tick();
        StallHz = 1'b0;
        #1;
        chk("t3_rel_pcin",  {25'b0, PCin},   32'd10);
        chk("t3_rel_stall", {31'b0, StallF}, 32'd0);
        push(7'd9);
        pop_chk("t3_rel");
        tick();
        imem_ready = 1'b1;

        // 4: branch while the fetch at PCF=12 is outstanding
        for (int a = 10; a < 12; a++) begin
            #1;
            chk("t4_pcf", {25'b0, pcf}, 32'(a));
            push(PC_W'(a));
            pop_chk("t4_run");
            tick();
        end
        imem_ready = 1'b0; PCSrcD = 1'b1; PCBranchD = 7'd40;
        #1;
        chk("t4_br_valid", {31'b0, InstrValidF}, 32'd0);
        chk("t4_br_stall", {31'b0, StallF},      32'd1);
        tick();
        PCSrcD = 1'b0; PCBranchD = 7'd0;
        #1;
        chk("t4_disc_req",   {31'b0, imem_req},    32'd1);
        chk("t4_disc_addr",  {25'b0, imem_addr},   32'd12);
        chk("t4_disc_valid", {31'b0, InstrValidF}, 32'd0);
        tick();
        imem_ready = 1'b1;
        #1;
        chk("t4_drop_valid", {31'b0, InstrValidF}, 32'd0);
        chk("t4_drop_stall", {31'b0, StallF},      32'd0);
        chk("t4_drop_pcin",  {25'b0, PCin},        32'd40);
        tick();
        #1;
        chk("t4_tgt_addr", {25'b0, imem_addr}, 32'd40);
        chk("t4_tgt_req",  {31'b0, imem_req},  32'd1);
        push(7'd40);
        pop_chk("t4_tgt");
        chk("t4_tgt_pcin", {25'b0, PCin}, 32'd41);
        tick();

        // 5: jump wins over branch; PC wraps at the top
        JumpD = 1'b1; PCJumpD = 7'd7; PCSrcD = 1'b1; PCBranchD = 7'd20;
        #1;
        chk("t5_both_pcin",  {25'b0, PCin},        32'd7);
        chk("t5_both_valid", {31'b0, InstrValidF}, 32'd0);
        tick();
        PCSrcD = 1'b0; PCJumpD = 7'd127;
        #1;
        chk("t5_jmp_pcf",  {25'b0, pcf},  32'd7);
        chk("t5_jmp_pcin", {25'b0, PCin}, 32'd127);
        tick();
        JumpD = 1'b0;
        #1;
        chk("t5_top_pcf", {25'b0, pcf}, 32'd127);
        push(7'd127);
        pop_chk("t5_top");
        chk("t5_wrap_pcin", {25'b0, PCin}, 32'd0);
        tick();
        #1;
        chk("t5_wrap_pcf", {25'b0, pcf}, 32'd0);

        // 6: reset while a redirect is pending in DISCARD
        imem_ready = 1'b0; PCSrcD = 1'b1; PCBranchD = 7'd99;
        #1;
        tick();
        PCSrcD = 1'b0;
        #1;
        chk("t6_disc_req", {31'b0, imem_req}, 32'd1);
        #2;
        rst_n = 1'b0;
        #1;
        chk("t6_rst_req",   {31'b0, imem_req},    32'd0);
        chk("t6_rst_stall", {31'b0, StallF},      32'd1);
        chk("t6_rst_valid", {31'b0, InstrValidF}, 32'd0);
        chk("t6_rst_pcin",  {25'b0, PCin},        32'd0);
        tick();
        rst_n = 1'b1; imem_ready = 1'b1;
        #1;
        chk("t6_idle_req", {31'b0, imem_req}, 32'd0);
        tick();
        #1;
        chk("t6_first_addr", {25'b0, imem_addr}, 32'd0);
        push(7'd0);
        pop_chk("t6_first");
        chk("t6_first_pcin", {25'b0, PCin}, 32'd1);
        chk("t6_sb_empty",   32'(sb.size()), 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
